// File: rtl/panel_pkg.sv
// Shared constants, FSM encoding and event record for the panel input controller.
package panel_pkg;
  localparam int CHAIN_W    = 24;
  localparam int NUM_CHAINS = 3;
  localparam int WIDTH      = CHAIN_W * NUM_CHAINS;
  localparam int EVT_IDX_W  = $clog2(WIDTH);
  localparam int EVT_W      = EVT_IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } panel_state_e;

  typedef struct packed {
    logic [EVT_IDX_W-1:0] idx;
    logic                 level;
  } panel_evt_t;
endpackage

// File: rtl/panel_if.sv
// Snapshot / event bus between the shell driver, the controller and the CPU side.
// PANEL_IRQ_EN adds irq_mask / irq.
interface panel_if;
  import panel_pkg::*;

  logic [WIDTH-1:0]     snap_data;
  logic                 snap_valid;
  logic [WIDTH-1:0]     stable_data;
  logic                 evt_valid;
  logic                 evt_ready;
  logic [EVT_IDX_W-1:0] evt_index;
  logic                 evt_level;
  logic                 evt_overflow;
  logic                 ovf_clear;
`ifdef PANEL_IRQ_EN
  logic                 irq_mask;
  logic                 irq;

  modport master (
    output snap_data, snap_valid, evt_ready, ovf_clear, irq_mask,
    input  stable_data, evt_valid, evt_index, evt_level, evt_overflow, irq
  );
  modport slave (
    input  snap_data, snap_valid, evt_ready, ovf_clear, irq_mask,
    output stable_data, evt_valid, evt_index, evt_level, evt_overflow, irq
  );
`else
  modport master (
    output snap_data, snap_valid, evt_ready, ovf_clear,
    input  stable_data, evt_valid, evt_index, evt_level, evt_overflow
  );
  modport slave (
    input  snap_data, snap_valid, evt_ready, ovf_clear,
    output stable_data, evt_valid, evt_index, evt_level, evt_overflow
  );
`endif
endinterface

// File: rtl/panel_evt_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is taken only
// when the head is popped in the same cycle.
module panel_evt_fifo
  import panel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  panel_evt_t din,
  output logic       full,
  input  logic       pop,
  output panel_evt_t dout,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  panel_evt_t    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_wr;
  logic          w_rd;

  // Extra pointer MSB distinguishes full from empty when the slots match.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd  = pop & ~empty;
  assign w_wr  = push & (~full | w_rd);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/panel_input_ctrl.sv
// Frame debouncer + bit-serial change scanner feeding the event FIFO.
// PANEL_IRQ_EN adds a registered, maskable interrupt.
module panel_input_ctrl
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic   clk,
  input  logic   reset,
  panel_if.slave bus
);
  localparam int                   CNT_W    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [EVT_IDX_W-1:0] IDX_LAST = EVT_IDX_W'(WIDTH - 1);

  panel_state_e         r_state;
  panel_state_e         w_state_nxt;
  logic [WIDTH-1:0]     r_cand;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_stable;
  logic [WIDTH-1:0]     r_target;
  logic [WIDTH-1:0]     r_diff;
  logic [EVT_IDX_W-1:0] r_idx;
  logic                 r_ovf;
  logic                 w_start;
  logic                 w_push;
  logic                 w_commit;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  panel_evt_t           w_din;
  panel_evt_t           w_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (bus.snap_valid) begin
      if (bus.snap_data == r_cand) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cand <= bus.snap_data;
        r_cnt  <= CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_push      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_cnt == CNT_MAX && r_cand != r_stable) begin
          w_start     = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_push = r_diff[r_idx];
        if (r_idx == IDX_LAST) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= '0;
      r_target <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
    end else begin
      if (w_start) begin
        r_target <= r_cand;
        r_diff   <= r_cand ^ r_stable;
        r_idx    <= '0;
      end else if (r_state == SCAN && r_idx != IDX_LAST) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_commit) r_stable <= r_target;
    end
  end

  assign w_din.idx   = r_idx;
  assign w_din.level = r_target[r_idx];
  assign w_pop       = ~w_empty & bus.evt_ready;
  // The scan never waits: a push that finds no room is simply lost.
  assign w_drop      = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset)              r_ovf <= 1'b0;
    else if (w_drop)        r_ovf <= 1'b1;
    else if (bus.ovf_clear) r_ovf <= 1'b0;
  end

  panel_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_din),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (w_head),
    .empty (w_empty)
  );

  assign bus.stable_data  = r_stable;
  assign bus.evt_valid    = ~w_empty;
  assign bus.evt_index    = w_head.idx;
  assign bus.evt_level    = w_head.level;
  assign bus.evt_overflow = r_ovf;

`ifdef PANEL_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= ~bus.irq_mask & (~w_empty | r_ovf);
  end
  assign bus.irq = r_irq;
`endif
endmodule

// File: tb/tb_panel_input_ctrl.sv
// Randomized and directed bench for panel_input_ctrl against a cycle-scheduled
// behavioural model (event list + bounded queue).
module tb_panel_input_ctrl;
  import panel_pkg::*;

  localparam int DEB   = 4;
  localparam int DEPTH = 8;

  typedef struct {
    logic [EVT_IDX_W-1:0] idx;
    logic                 lvl;
  } ev_t;
  typedef struct {
    int  at;
    ev_t ev;
  } sch_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  panel_if bus ();

  panel_input_ctrl #(.DEBOUNCE_FRAMES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [WIDTH-1:0] got, logic [WIDTH-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state: decisions scheduled as absolute edge numbers.
  logic [WIDTH-1:0] m_stable, m_cand, m_target;
  int   m_cnt, cyc, m_e, m_commit;
  bit   m_busy, m_ovf, m_irq;
  ev_t  q[$];
  sch_t sched[$];
  int   n_pop;
  logic [EVT_IDX_W-1:0] last_idx;

  task automatic model_reset();
    m_stable = '0; m_cand = '0; m_target = '0; m_cnt = 0;
    m_busy = 0; m_ovf = 0; m_irq = 0;
    q.delete(); sched.delete();
  endtask

  task automatic model_edge();
    bit   start, pop, drop;
    sch_t s;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
`ifdef PANEL_IRQ_EN
    m_irq = !bus.irq_mask && (q.size() != 0 || m_ovf);
`endif
    start = !m_busy && m_cnt == DEB && m_cand != m_stable;
    pop   = q.size() != 0 && bus.evt_ready;
    drop  = 0;
    if (pop) void'(q.pop_front());
    if (sched.size() != 0 && sched[0].at == cyc) begin
      s = sched.pop_front();
      if (q.size() < DEPTH) q.push_back(s.ev);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (bus.ovf_clear) m_ovf = 0;
    if (m_busy && cyc == m_commit) begin
      m_stable = m_target;
      m_busy   = 0;
    end
    if (start) begin
      m_busy = 1; m_e = cyc; m_target = m_cand;
      for (int i = 0; i < WIDTH; i++)
        if (m_cand[i] != m_stable[i]) begin
          s.at = cyc + 1 + i; s.ev.idx = EVT_IDX_W'(i); s.ev.lvl = m_cand[i];
          sched.push_back(s);
        end
      m_commit = cyc + 1 + WIDTH;
    end
    if (bus.snap_valid) begin
      if (bus.snap_data == m_cand) m_cnt = (m_cnt < DEB) ? m_cnt + 1 : DEB;
      else begin
        m_cand = bus.snap_data;
        m_cnt  = 1;
      end
    end
  endtask

  task automatic check_outs();
    chk("evt_valid", WIDTH'(bus.evt_valid), WIDTH'(q.size() != 0));
    if (q.size() != 0) begin
      chk("evt_index", WIDTH'(bus.evt_index), WIDTH'(q[0].idx));
      chk("evt_level", WIDTH'(bus.evt_level), WIDTH'(q[0].lvl));
    end
    chk("stable_data", bus.stable_data, m_stable);
    chk("evt_overflow", WIDTH'(bus.evt_overflow), WIDTH'(m_ovf));
`ifdef PANEL_IRQ_EN
    chk("irq", WIDTH'(bus.irq), WIDTH'(m_irq));
`endif
  endtask

  task automatic step();
    if (bus.evt_valid && bus.evt_ready) begin
      n_pop++;
      last_idx = bus.evt_index;
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic snap(input logic [WIDTH-1:0] d);
    bus.snap_data = d; bus.snap_valid = 1'b1;
    step();
    bus.snap_valid = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_pop = 0;
  endtask

  task automatic wait_scan_edge(input int off);
    for (int k = 0; k < 200 && !(m_busy && cyc == m_e + off); k++) step();
  endtask

  function automatic logic [WIDTH-1:0] rnd72();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] pat, pool [3];
  int   sel;

  initial begin
    cyc = 0; n_pop = 0; last_idx = '0;
    model_reset();
    reset = 1'b1;
    bus.snap_data = '0; bus.snap_valid = 1'b0;
    bus.evt_ready = 1'b0; bus.ovf_clear = 1'b0;
`ifdef PANEL_IRQ_EN
    bus.irq_mask = 1'b0;
`endif
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    n_pop = 0;

    // All-zero panel settles without any scan.
    repeat (4) snap('0);
    idle(80);
    chk("zero_no_evt", WIDTH'(n_pop), WIDTH'(0));
    chk("zero_stable", bus.stable_data, '0);

    // Two bits rise.
    pat = '0; pat[3] = 1'b1; pat[50] = 1'b1;
    bus.evt_ready = 1'b1;
    repeat (4) snap(pat);
    idle(80);
    chk("two_bits_pops", WIDTH'(n_pop), WIDTH'(2));
    chk("two_bits_last", WIDTH'(last_idx), WIDTH'(50));
    chk("two_bits_stable", bus.stable_data, pat);

    // Bounce A,B,A,A,A,A yields one event.
    do_reset();
    pat = '0; pat[10] = 1'b1;
    snap(pat); snap('0);
    repeat (4) snap(pat);
    idle(80);
    chk("bounce_pops", WIDTH'(n_pop), WIDTH'(1));
    chk("bounce_idx", WIDTH'(last_idx), WIDTH'(10));

    // 12 bits with consumer stalled: 8 queued, overflow, full commit.
    do_reset();
    bus.evt_ready = 1'b0;
    pat = '0;
    for (int i = 0; i < 12; i++) pat[i * 5 + 2] = 1'b1;
    repeat (4) snap(pat);
    idle(80);
    chk("ovf_set", WIDTH'(bus.evt_overflow), WIDTH'(1));
    chk("ovf_stable", bus.stable_data, pat);
    bus.evt_ready = 1'b1;
    idle(12);
    chk("ovf_drain", WIDTH'(n_pop), WIDTH'(8));
    chk("ovf_last", WIDTH'(last_idx), WIDTH'(37));
    bus.ovf_clear = 1'b1; step(); bus.ovf_clear = 1'b0;
    step();
    chk("ovf_cleared", WIDTH'(bus.evt_overflow), WIDTH'(0));

    // Full FIFO popped in the same cycle as the ninth push.
    do_reset();
    bus.evt_ready = 1'b0;
    pat = '0;
    for (int i = 0; i < 8; i++) pat[i] = 1'b1;
    pat[20] = 1'b1;
    repeat (4) snap(pat);
    wait_scan_edge(20);
    bus.evt_ready = 1'b1; step(); bus.evt_ready = 1'b0;
    idle(60);
    chk("full_pop_no_ovf", WIDTH'(bus.evt_overflow), WIDTH'(0));
    bus.evt_ready = 1'b1;
    idle(12);
    chk("full_pop_total", WIDTH'(n_pop), WIDTH'(9));
    chk("full_pop_last", WIDTH'(last_idx), WIDTH'(20));

    // Reset while the scan is at index 30.
    do_reset();
    bus.evt_ready = 1'b0;
    pat = '0;
    for (int i = 0; i < 40; i += 3) pat[i] = 1'b1;
    repeat (4) snap(pat);
    wait_scan_edge(30);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_scan_valid", WIDTH'(bus.evt_valid), WIDTH'(0));
    chk("rst_scan_stable", bus.stable_data, '0);
`ifdef PANEL_IRQ_EN
    chk("rst_scan_irq", WIDTH'(bus.irq), WIDTH'(0));
`endif
    idle(80);
    chk("rst_scan_idle", bus.stable_data, '0);

    // Randomized traffic from a small pool of sparse panel images.
    for (int i = 0; i < 3; i++) pool[i] = rnd72() & rnd72() & rnd72();
    sel = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) pool[$urandom_range(0, 2)] = rnd72() & rnd72();
      if ($urandom_range(0, 5) == 0) sel = $urandom_range(0, 2);
      bus.snap_valid = ($urandom_range(0, 2) == 0);
      bus.snap_data  = pool[sel];
      bus.evt_ready  = ($urandom_range(0, 2) != 0);
      bus.ovf_clear  = ($urandom_range(0, 15) == 0);
`ifdef PANEL_IRQ_EN
      bus.irq_mask   = ($urandom_range(0, 7) == 0);
`endif
      reset = ($urandom_range(0, 1499) == 0);
      step();
    end
    reset = 1'b0;
    bus.snap_valid = 1'b0;
    bus.evt_ready  = 1'b1;
    idle(100);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
